// File: rtl/dmem_sys_pkg.sv
// Shared definitions for the data-side memory subsystem: access sizes,
// MMIO register offsets and the address-decode result.
package dmem_sys_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] SIZE_B = 3'b001;
  localparam logic [2:0] SIZE_H = 3'b010;
  localparam logic [2:0] SIZE_W = 3'b100;

  localparam logic [4:0] MMIO_TOHOST    = 5'h00;
  localparam logic [4:0] MMIO_CONS_TX   = 5'h04;
  localparam logic [4:0] MMIO_CONS_STAT = 5'h08;
  localparam logic [4:0] MMIO_MTIME_LO  = 5'h10;
  localparam logic [4:0] MMIO_MTIME_HI  = 5'h14;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_MMIO,
    REGION_NONE
  } region_e;

  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] ofs);
    case (size)
      SIZE_B:  byte_en = 4'b0001 << ofs;
      SIZE_H:  byte_en = 4'b0011 << ofs;
      SIZE_W:  byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] lane_rep(input logic [2:0] size, input logic [XLEN-1:0] data);
    case (size)
      SIZE_B:  lane_rep = {4{data[7:0]}};
      SIZE_H:  lane_rep = {2{data[15:0]}};
      default: lane_rep = data;
    endcase
  endfunction

endpackage

// File: rtl/dmem_sys_sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is taken
// only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dmem_sys.sv
// Data-side memory subsystem: byte-lane data RAM plus an MMIO window holding
// tohost, a console TX FIFO and a 64-bit cycle counter. Loads are combinational.
module dmem_sys
  import dmem_sys_pkg::*;
#(
  parameter logic [XLEN-1:0] RAM_BASE   = 32'h0000_0000,
  parameter int              RAM_WORDS  = 4096,
  parameter logic [XLEN-1:0] MMIO_BASE  = 32'hF000_0000,
  parameter int              CONS_DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            adr_v_i,
  input  logic [XLEN-1:0] adr_i,
  input  logic            is_store_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [2:0]      access_size_i,
  output logic [XLEN-1:0] load_data_o,
  output logic            misalign_o,
  output logic            bus_err_o,
  output logic            tohost_v_o,
  output logic [XLEN-1:0] tohost_data_o,
  output logic            cons_valid_o,
  output logic [7:0]      cons_data_o,
  input  logic            cons_ready_i,
  output logic [63:0]     mtime_o
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int CW     = $clog2(CONS_DEPTH) + 1;

  logic [XLEN-1:0] mem [RAM_WORDS];

  region_e         region;
  logic [XLEN-1:0] ram_off;
  logic [RAM_AW-1:0] ram_idx;
  logic [1:0]      ofs;
  logic [4:0]      mmio_ofs;
  logic            size_onehot;
  logic            mmio_err;
  logic            acc_ok;
  logic            ram_wr;
  logic            mmio_wr;
  logic            mmio_rd;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata_rep;
  logic [XLEN-1:0] ram_word;
  logic [XLEN-1:0] ram_shift;

  logic [XLEN-1:0] tohost_data_q;
  logic            tohost_v_q;
  logic [63:0]     mtime_q;
  logic [31:0]     mtime_hi_q;
  logic            cons_ovf_q;

  logic            cons_push;
  logic            cons_pop;
  logic            cons_full;
  logic            cons_empty;
  logic [CW-1:0]   cons_count;

  assign ofs      = adr_i[1:0];
  assign mmio_ofs = adr_i[4:0];
  // Offset subtraction wraps below RAM_BASE, so one unsigned compare covers both bounds.
  assign ram_off  = adr_i - RAM_BASE;
  assign ram_idx  = ram_off[RAM_AW+1:2];

  always_comb begin
    region = REGION_NONE;
    if (ram_off < XLEN'(4 * RAM_WORDS))
      region = REGION_RAM;
    else if (adr_i[XLEN-1:5] == MMIO_BASE[XLEN-1:5])
      region = REGION_MMIO;
  end

  assign size_onehot = (access_size_i == SIZE_B) || (access_size_i == SIZE_H) ||
                       (access_size_i == SIZE_W);

  assign misalign_o = adr_v_i & (~size_onehot |
                                 ((access_size_i == SIZE_H) & adr_i[0]) |
                                 ((access_size_i == SIZE_W) & (ofs != 2'b00)));

  always_comb begin
    mmio_err = 1'b1;
    case (mmio_ofs)
      MMIO_CONS_TX:   mmio_err = 1'b0;
      MMIO_TOHOST,
      MMIO_CONS_STAT,
      MMIO_MTIME_LO,
      MMIO_MTIME_HI:  mmio_err = (access_size_i != SIZE_W);
      default:        mmio_err = 1'b1;
    endcase
  end

  assign bus_err_o = adr_v_i & ((region == REGION_NONE) |
                                ((region == REGION_MMIO) & mmio_err));

  assign acc_ok  = adr_v_i & ~misalign_o & ~bus_err_o;
  assign ram_wr  = acc_ok & is_store_i & reset_n & (region == REGION_RAM);
  assign mmio_wr = acc_ok & is_store_i & reset_n & (region == REGION_MMIO);
  assign mmio_rd = acc_ok & ~is_store_i & (region == REGION_MMIO);

  assign be        = byte_en(access_size_i, ofs);
  assign wdata_rep = lane_rep(access_size_i, store_data_i);

  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[ram_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  assign ram_word  = mem[ram_idx];
  assign ram_shift = ram_word >> {ofs, 3'b000};

  always_comb begin
    load_data_o = '0;
    if (acc_ok && !is_store_i) begin
      case (region)
        REGION_RAM: begin
          case (access_size_i)
            SIZE_B:  load_data_o = XLEN'(ram_shift[7:0]);
            SIZE_H:  load_data_o = XLEN'(ram_shift[15:0]);
            default: load_data_o = ram_shift;
          endcase
        end
        REGION_MMIO: begin
          case (mmio_ofs)
            MMIO_TOHOST:    load_data_o = tohost_data_q;
            MMIO_CONS_STAT: load_data_o = XLEN'({cons_count, 2'b00, cons_ovf_q, cons_full});
            MMIO_MTIME_LO:  load_data_o = mtime_q[31:0];
            MMIO_MTIME_HI:  load_data_o = mtime_hi_q;
            default:        load_data_o = '0;
          endcase
        end
        default: load_data_o = '0;
      endcase
    end
  end

  assign cons_push = mmio_wr & (mmio_ofs == MMIO_CONS_TX);
  assign cons_pop  = cons_valid_o & cons_ready_i;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (CONS_DEPTH)
  ) u_cons_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (cons_push),
    .pop     (cons_ready_i),
    .wdata   (store_data_i[7:0]),
    .rdata   (cons_data_o),
    .full    (cons_full),
    .empty   (cons_empty),
    .count   (cons_count)
  );

  assign cons_valid_o = ~cons_empty;

  // The hi shadow lets software read a coherent 64-bit time as LO then HI.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tohost_v_q    <= 1'b0;
      tohost_data_q <= '0;
      mtime_q       <= '0;
      mtime_hi_q    <= '0;
      cons_ovf_q    <= 1'b0;
    end else begin
      mtime_q <= mtime_q + 64'd1;
      if (mmio_wr && (mmio_ofs == MMIO_TOHOST) && !tohost_v_q) begin
        tohost_v_q    <= 1'b1;
        tohost_data_q <= store_data_i;
      end
      if (cons_push && cons_full && !cons_pop)
        cons_ovf_q <= 1'b1;
      else if (mmio_wr && (mmio_ofs == MMIO_CONS_STAT) && store_data_i[1])
        cons_ovf_q <= 1'b0;
      if (mmio_rd && (mmio_ofs == MMIO_MTIME_LO))
        mtime_hi_q <= mtime_q[63:32];
    end
  end

  assign tohost_v_o    = tohost_v_q;
  assign tohost_data_o = tohost_data_q;
  assign mtime_o       = mtime_q;

endmodule

// File: tb/tb_dmem_sys.sv
// Directed bench for dmem_sys: a byte-level memory/queue model checks every
// output each cycle, and literal expectations pin the key test-plan values.
module tb_dmem_sys;
  import dmem_sys_pkg::*;

  localparam int L_LD = 0, L_MIS = 1, L_BE = 2, L_TV = 3, L_TD = 4, L_CV = 5, L_CD = 6, L_MT = 7;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        adr_v;
  logic [31:0] adr;
  logic        is_store;
  logic [31:0] sd;
  logic [2:0]  size;
  logic [31:0] load_data;
  logic        misalign;
  logic        bus_err;
  logic        tohost_v;
  logic [31:0] tohost_data;
  logic        cons_valid;
  logic [7:0]  cons_data;
  logic        cons_ready;
  logic [63:0] mtime;

  dmem_sys dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .adr_v_i       (adr_v),
    .adr_i         (adr),
    .is_store_i    (is_store),
    .store_data_i  (sd),
    .access_size_i (size),
    .load_data_o   (load_data),
    .misalign_o    (misalign),
    .bus_err_o     (bus_err),
    .tohost_v_o    (tohost_v),
    .tohost_data_o (tohost_data),
    .cons_valid_o  (cons_valid),
    .cons_data_o   (cons_data),
    .cons_ready_i  (cons_ready),
    .mtime_o       (mtime)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  bit lit_en [8];
  logic [63:0] lit_exp [8];
  bit poke_en = 1'b0;
  logic [63:0] poke_val = '0;

  // model state
  bit [7:0]    ram_m [int unsigned];
  bit          m_tv = 1'b0;
  logic [31:0] m_td = '0;
  bit [7:0]    m_q [$];
  bit          m_ovf = 1'b0;
  logic [63:0] m_mt = '0;
  logic [31:0] m_sh = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] lit_act(input int s);
    case (s)
      L_LD:    return 64'(load_data);
      L_MIS:   return 64'(misalign);
      L_BE:    return 64'(bus_err);
      L_TV:    return 64'(tohost_v);
      L_TD:    return 64'(tohost_data);
      L_CV:    return 64'(cons_valid);
      L_CD:    return 64'(cons_data);
      default: return mtime;
    endcase
  endfunction

  function automatic string lit_name(input int s);
    case (s)
      L_LD:    return "lit_load_data";
      L_MIS:   return "lit_misalign";
      L_BE:    return "lit_bus_err";
      L_TV:    return "lit_tohost_v";
      L_TD:    return "lit_tohost_data";
      L_CV:    return "lit_cons_valid";
      L_CD:    return "lit_cons_data";
      default: return "lit_mtime";
    endcase
  endfunction

  always @(negedge clk) begin : compare
    int unsigned n;
    bit is_ram, is_mmio, mis, berr, ok, known, pop;
    logic [4:0] o;
    logic [31:0] ld;
    if (poke_en) m_mt = poke_val;
    n = (size == 3'b001) ? 1 : (size == 3'b010) ? 2 : (size == 3'b100) ? 4 : 0;
    is_ram  = (adr < 32'h0000_4000);
    is_mmio = ((adr >> 5) == (32'hF000_0000 >> 5));
    o = adr[4:0];
    mis  = adr_v && (n == 0 || (adr % n) != 0);
    berr = adr_v && ((!is_ram && !is_mmio) ||
                     (is_mmio && !(o == 5'h04 || ((o inside {5'h00, 5'h08, 5'h10, 5'h14}) && n == 4))));
    ok = adr_v && !mis && !berr;
    ld = '0;
    known = 1'b1;
    if (ok && !is_store) begin
      if (is_ram) begin
        for (int unsigned i = 0; i < n; i++) begin
          if (ram_m.exists(adr + i)) ld = ld | (32'(ram_m[adr + i]) << (8 * i));
          else known = 1'b0;
        end
      end else begin
        case (o)
          5'h00:   ld = m_td;
          5'h08:   ld = (32'(m_q.size()) << 4) | (32'(m_ovf) << 1) | 32'(m_q.size() == 8);
          5'h10:   ld = m_mt[31:0];
          5'h14:   ld = m_sh;
          default: ld = '0;
        endcase
      end
    end
    if (chk_en) begin
      check("misalign", 64'(misalign), 64'(mis));
      check("bus_err", 64'(bus_err), 64'(berr));
      if (known) check("load_data", 64'(load_data), 64'(ld));
      check("tohost_v", 64'(tohost_v), 64'(m_tv));
      check("tohost_data", 64'(tohost_data), 64'(m_td));
      check("cons_valid", 64'(cons_valid), 64'(m_q.size() != 0));
      check("cons_data", 64'(cons_data), (m_q.size() != 0) ? 64'(m_q[0]) : 64'd0);
      check("mtime", mtime, m_mt);
      for (int s = 0; s < 8; s++) begin
        if (lit_en[s]) check(lit_name(s), lit_act(s), lit_exp[s]);
      end
    end
    if (!reset_n) begin
      m_tv = 1'b0; m_td = '0; m_q.delete(); m_ovf = 1'b0; m_mt = '0; m_sh = '0;
    end else begin
      pop = (m_q.size() != 0) && cons_ready;
      if (ok && is_store && is_ram)
        for (int unsigned i = 0; i < n; i++) ram_m[adr + i] = sd[8*i +: 8];
      if (ok && is_store && is_mmio && o == 5'h00 && !m_tv) begin
        m_tv = 1'b1; m_td = sd;
      end
      if (pop) void'(m_q.pop_front());
      if (ok && is_store && is_mmio && o == 5'h04) begin
        if (m_q.size() < 8) m_q.push_back(sd[7:0]);
        else m_ovf = 1'b1;
      end
      if (ok && is_store && is_mmio && o == 5'h08 && sd[1]) m_ovf = 1'b0;
      if (ok && !is_store && is_mmio && o == 5'h10) m_sh = m_mt[63:32];
      m_mt = m_mt + 64'd1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int s = 0; s < 8; s++) lit_en[s] = 1'b0;
    poke_en = 1'b0;
  endtask

  task automatic lit(input int s, input logic [63:0] e);
    lit_en[s] = 1'b1;
    lit_exp[s] = e;
  endtask

  task automatic acc(input bit st, input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
    adr_v = 1'b1; is_store = st; adr = a; sd = d; size = sz;
  endtask

  task automatic idle();
    adr_v = 1'b0; is_store = 1'b0; adr = '0; sd = '0; size = SIZE_W;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < 8; s++) begin lit_en[s] = 1'b0; lit_exp[s] = '0; end
    reset_n = 1'b0; cons_ready = 1'b0;
    idle();
    tick();
    chk_en = 1'b1;
    lit(L_MT, 0); lit(L_TV, 0); lit(L_CV, 0); lit(L_CD, 0); lit(L_LD, 0);
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    acc(0, 32'hF000_0010, 0, SIZE_W); lit(L_LD, 10); tick();

    // RAM byte lanes
    acc(1, 32'h100, 32'hDEADBEEF, SIZE_W); tick();
    acc(0, 32'h102, 0, SIZE_B); lit(L_LD, 32'h0000_00AD); tick();
    acc(0, 32'h102, 0, SIZE_H); lit(L_LD, 32'h0000_DEAD); tick();
    acc(1, 32'h101, 32'h11, SIZE_B); tick();
    acc(0, 32'h100, 0, SIZE_W); lit(L_LD, 32'hDEAD11EF); tick();
    acc(1, 32'h104, 0, SIZE_W); tick();
    acc(1, 32'h106, 32'h1234CAFE, SIZE_H); tick();
    acc(1, 32'h107, 32'h77, SIZE_B); tick();
    acc(0, 32'h104, 0, SIZE_W); lit(L_LD, 32'h77FE_0000); tick();

    // alignment, decode and suppression
    acc(0, 32'h102, 0, SIZE_W); lit(L_MIS, 1); lit(L_LD, 0); tick();
    acc(1, 32'h102, 32'hFFFF_FFFF, SIZE_W); lit(L_MIS, 1); tick();
    acc(1, 32'h101, 32'hFFFF_FFFF, SIZE_H); lit(L_MIS, 1); tick();
    acc(0, 32'h100, 0, 3'b011); lit(L_MIS, 1); lit(L_LD, 0); tick();
    acc(0, 32'h100, 0, SIZE_W); lit(L_LD, 32'hDEAD11EF); lit(L_MIS, 0); tick();
    acc(0, 32'h8000_0000, 0, SIZE_W); lit(L_BE, 1); lit(L_LD, 0); tick();
    acc(1, 32'h3FFC, 32'hA5A5_5A5A, SIZE_W); lit(L_BE, 0); tick();
    acc(0, 32'h3FFC, 0, SIZE_W); lit(L_LD, 32'hA5A5_5A5A); tick();
    acc(0, 32'h4000, 0, SIZE_W); lit(L_BE, 1); tick();
    acc(0, 32'hF000_000C, 0, SIZE_W); lit(L_BE, 1); tick();
    acc(0, 32'hF000_0020, 0, SIZE_W); lit(L_BE, 1); tick();
    acc(0, 32'hF000_0008, 0, SIZE_B); lit(L_BE, 1); tick();
    idle(); lit(L_LD, 0); lit(L_MIS, 0); lit(L_BE, 0); tick();

    // console overflow and drain
    for (int i = 1; i <= 9; i++) begin
      acc(1, 32'hF000_0004, 32'(i), SIZE_B); tick();
    end
    acc(0, 32'hF000_0008, 0, SIZE_W); lit(L_LD, 32'h83); lit(L_CV, 1); lit(L_CD, 1); tick();
    acc(0, 32'hF000_0004, 0, SIZE_W); lit(L_LD, 0); lit(L_BE, 0); tick();
    idle(); cons_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      lit(L_CD, i); lit(L_CV, 1); tick();
    end
    lit(L_CV, 0); tick();
    cons_ready = 1'b0;
    acc(1, 32'hF000_0008, 32'h2, SIZE_W); tick();
    acc(0, 32'hF000_0008, 0, SIZE_W); lit(L_LD, 0); tick();

    // full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) begin
      acc(1, 32'hF000_0004, 32'h20 + 32'(i), SIZE_B); tick();
    end
    cons_ready = 1'b1;
    acc(1, 32'hF000_0004, 32'h28, SIZE_B); lit(L_CD, 32'h20); tick();
    cons_ready = 1'b0;
    acc(0, 32'hF000_0008, 0, SIZE_W); lit(L_LD, 32'h81); tick();
    idle(); cons_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      lit(L_CD, 32'h21 + 64'(i)); tick();
    end
    lit(L_CV, 0); tick();
    cons_ready = 1'b0;

    // tohost capture is first-write-wins
    acc(1, 32'hF000_0000, 32'h1, SIZE_W); lit(L_TV, 0); tick();
    acc(1, 32'hF000_0000, 32'h2, SIZE_W); lit(L_TV, 1); lit(L_TD, 1); tick();
    acc(0, 32'hF000_0000, 0, SIZE_W); lit(L_LD, 1); lit(L_TD, 1); tick();
    acc(1, 32'hF000_0000, 32'h3, SIZE_H); lit(L_BE, 1); tick();

    // mtime hi shadow across the low-word carry
    idle();
    force dut.mtime_q = 64'h0000_0000_FFFF_FFFE;
    poke_val = 64'h0000_0000_FFFF_FFFE; poke_en = 1'b1;
    #1;
    release dut.mtime_q;
    tick();
    acc(0, 32'hF000_0010, 0, SIZE_W); lit(L_LD, 32'hFFFF_FFFF); tick();
    acc(0, 32'hF000_0014, 0, SIZE_W); lit(L_LD, 0); lit(L_MT, 64'h1_0000_0000); tick();
    acc(0, 32'hF000_0010, 0, SIZE_W); lit(L_LD, 1); tick();
    acc(0, 32'hF000_0014, 0, SIZE_W); lit(L_LD, 1); tick();
    idle();
    force dut.mtime_q = 64'hFFFF_FFFF_FFFF_FFFF;
    poke_val = 64'hFFFF_FFFF_FFFF_FFFF; poke_en = 1'b1;
    #1;
    release dut.mtime_q;
    lit(L_MT, 64'hFFFF_FFFF_FFFF_FFFF); tick();
    lit(L_MT, 0); tick();

    // reset mid-operation drops a concurrent store
    acc(1, 32'hF000_0004, 32'h55, SIZE_B); tick();
    reset_n = 1'b0;
    acc(1, 32'h100, 32'h1234_5678, SIZE_W); lit(L_CV, 1); lit(L_TV, 1); tick();
    reset_n = 1'b1;
    acc(0, 32'h100, 0, SIZE_W);
    lit(L_LD, 32'hDEAD11EF); lit(L_CV, 0); lit(L_TV, 0); lit(L_TD, 0); lit(L_MT, 0);
    tick();
    idle(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_sys.md
Name: dmem_sys

Overview:
- Data-side memory subsystem sitting directly downstream of the core data interface (adr_v/adr/is_store/store_data/load_data/access_size).
- Contains word-organised data RAM with byte-lane writes, plus an MMIO window: tohost test-end register, console TX FIFO with valid/ready drain, 64-bit free-running cycle counter.
- Loads are combinational (same cycle as adr_v), because the core does not stall. Stores commit on the rising clk edge.

Parameters:
- XLEN, 32, data/address width (from riscv_pkg).
- RAM_BASE, 32'h0000_0000, byte base address of data RAM.
- RAM_WORDS, 4096, RAM depth in 32-bit words; power of 2.
- MMIO_BASE, 32'hF000_0000, base of 32-byte MMIO window.
- CONS_DEPTH, 8, console FIFO entries; power of 2, >= 2.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- adr_v_i  in  1  data access valid this cycle.
- adr_i  in  XLEN  byte address.
- is_store_i  in  1  1 = store, 0 = load.
- store_data_i  in  XLEN  store data, right-aligned.
- access_size_i  in  3  one-hot: 001 byte, 010 half, 100 word.
- load_data_o  out  XLEN  load data, right-aligned and zero-extended; the core sign-extends.
- misalign_o  out  1  combinational: current access is misaligned.
- bus_err_o  out  1  combinational: valid access hits no mapped region, or an illegal MMIO size.
- tohost_v_o  out  1  sticky: tohost has been written.
- tohost_data_o  out  XLEN  value captured by the first tohost write.
- cons_valid_o  out  1  console FIFO non-empty.
- cons_data_o  out  8  console FIFO head byte.
- cons_ready_i  in  1  console sink accepts the head byte.
- mtime_o  out  64  free-running cycle counter.

Behaviour:
- Reset values: tohost_v_o=0, tohost_data_o=0, cons_valid_o=0, cons_data_o=0, mtime_o=0, FIFO pointers/count=0, overflow flag=0, mtime_hi shadow=0. RAM contents are not reset.
- Decode:
  - RAM hit: RAM_BASE <= adr < RAM_BASE + 4*RAM_WORDS.
  - MMIO hit: adr[31:5] == MMIO_BASE[31:5].
  - Otherwise: unmapped.
- Alignment:
  - misalign_o = adr_v_i & ((half & adr[0]) | (word & adr[1:0]!=0)).
  - A non-one-hot access_size counts as misaligned.
- Suppression: a misaligned or bus_err access writes nothing, returns load_data_o=0, and has no side effects (no FIFO push, no shadow update).
- Idle: when adr_v_i=0, load_data_o=0 and nothing is written.
- RAM load: word = mem[adr index]; load_data_o = (word >> 8*adr[1:0]) masked to the access size.
- RAM store: byte enables are derived from size and offset; data is replicated into lanes; only enabled bytes are written at the clk edge.
- MMIO map (offset: access):
  - 0x00 TOHOST (W, word only): if tohost_v_o==0, capture data and set tohost_v_o; later writes are ignored until reset. Read returns tohost_data_o.
  - 0x04 CONS_TX (W, any size; uses [7:0]): push the byte.
    - If full and no pop in the same cycle: drop the byte and set the sticky overflow flag.
    - If full with a simultaneous pop: the push is accepted.
    - Read returns 0.
  - 0x08 CONS_STATUS (R, word only): bit0 full, bit1 overflow, bits[7:4] count. Writing bit1=1 clears overflow. Other bits are read-only.
  - 0x10 MTIME_LO (R, word only): returns mtime[31:0]; in the same cycle, latches mtime[63:32] into the hi shadow.
  - 0x14 MTIME_HI (R, word only): returns the hi shadow.
  - Other MMIO offsets, or a non-word size where word is required: bus_err_o=1.
- mtime: increments by 1 every cycle after reset, wraps at 2^64 to 0, and is not writable. The value read is the pre-increment register value.
- Console FIFO:
  - Pop occurs when cons_valid_o & cons_ready_i at the edge.
  - cons_data_o shows the head combinationally from the FIFO array.
  - Pop on empty: no-op.
  - Push and pop in the same cycle: count unchanged.
  - Pointers wrap modulo CONS_DEPTH.
  - Count is log2(CONS_DEPTH)+1 bits wide.
- Reset asserted mid-operation: all state except RAM returns to reset values at that edge; a store presented in the same cycle as reset is dropped.

Decomposition:
- riscv_pkg additions:
  - access-size one-hot constants (SIZE_B, SIZE_H, SIZE_W).
  - MMIO offset constants (MMIO_TOHOST, MMIO_CONS_TX, MMIO_CONS_STAT, MMIO_MTIME_LO, MMIO_MTIME_HI).
  - enum typedef for decode result (REGION_RAM, REGION_MMIO, REGION_NONE).
- One sub-module, sync_fifo: parameterised width/depth, push/pop/full/empty/count. It is instantiated for the console path.

Test Plan:
- Store word 0xDEADBEEF @0x100; load byte @0x102 -> 0x000000AD; load half @0x102 -> 0x0000DEAD; store byte 0x11 @0x101 then load word @0x100 -> 0xDEAD11EF.
- Load word @0x102 -> misalign_o=1, load_data_o=0; subsequent load @0x100 shows RAM unchanged; load @0x8000_0000 -> bus_err_o=1.
- Write 9 bytes to CONS_TX (depth 8) with cons_ready_i=0 -> cons_valid_o=1, STATUS=0x83 (count 8, overflow, full); assert ready for 8 cycles -> bytes 1..8 in order, then cons_valid_o=0.
- With FIFO full, push and pop in the same cycle -> count stays 8, no overflow set, new byte emerges last.
- Write 0x1 then 0x2 to TOHOST -> tohost_v_o=1 from the next cycle, tohost_data_o stays 0x1.
- After exactly 10 cycles out of reset, read MTIME_LO -> 10; force mtime near 2^32-1, read LO then HI -> the HI value equals the one latched at the LO read, even across the carry.
